// File: rtl/core_pkg.sv
// Shared core types and constants used by the front-end pipeline stages.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // S_HELD: the decode-stage instruction lives in the hold buffer, not on the memory bus.
  typedef enum logic {
    S_RUN,
    S_HELD
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, synchronous I-memory request and IF/ID register with a
// stall capture buffer so the decode bundle stays stable while the memory is idle.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     IMEM_AW  = 14
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall_if,
  input  logic               i_stall_id,
  input  logic               i_flush_if_id,
  input  logic               i_redirect_valid,
  input  logic [XLEN-1:0]    i_redirect_pc,
  output logic               o_imem_req,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic [XLEN-1:0]    i_imem_rdata,
  output logic               o_if_id_valid,
  output logic [XLEN-1:0]    o_if_id_pc,
  output logic [XLEN-1:0]    o_if_id_pc4,
  output logic [XLEN-1:0]    o_if_id_instr
);

  logic [XLEN-1:0] r_pc;
  logic            r_f1_valid;
  logic [XLEN-1:0] r_f1_pc;
  fetch_state_e    r_state;
  logic [XLEN-1:0] r_hold_instr;

  logic [XLEN-1:0] w_pc_next;
  logic            w_f1_valid_next;
  logic [XLEN-1:0] w_f1_pc_next;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] w_hold_instr_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_redirect;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = i_redirect_valid && !i_stall_id;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc         <= RESET_PC;
      r_f1_valid   <= 1'b0;
      r_f1_pc      <= '0;
      r_state      <= S_RUN;
      r_hold_instr <= NOP_INSTR;
    end else begin
      r_pc         <= w_pc_next;
      r_f1_valid   <= w_f1_valid_next;
      r_f1_pc      <= w_f1_pc_next;
      r_state      <= w_state_next;
      r_hold_instr <= w_hold_instr_next;
    end
  end

  always_comb begin
    w_pc_next         = r_pc;
    w_f1_valid_next   = r_f1_valid;
    w_f1_pc_next      = r_f1_pc;
    w_state_next      = r_state;
    w_hold_instr_next = r_hold_instr;

    if (w_redirect) begin
      // Wrong-path fetch in flight is dropped: one bubble reaches decode.
      w_pc_next       = {i_redirect_pc[XLEN-1:2], 2'b00};
      w_f1_valid_next = 1'b0;
      w_state_next    = S_RUN;
    end else if (i_stall_id) begin
      // Memory output is only trustworthy on the first stalled edge; latch it then.
      if (r_state == S_RUN) begin
        w_hold_instr_next = i_imem_rdata;
        w_state_next      = S_HELD;
      end
    end else if (i_flush_if_id && !i_stall_if) begin
      w_pc_next       = w_pc_plus4;
      w_f1_pc_next    = r_pc;
      w_f1_valid_next = 1'b0;
      w_state_next    = S_RUN;
    end else if (i_stall_if) begin
      w_f1_valid_next = 1'b0;
      w_state_next    = S_RUN;
    end else begin
      w_pc_next       = w_pc_plus4;
      w_f1_pc_next    = r_pc;
      w_f1_valid_next = 1'b1;
      w_state_next    = S_RUN;
    end
  end

  assign o_imem_req    = i_reset && !i_stall_if;
  assign o_imem_addr   = r_pc[IMEM_AW+1:2];
  assign o_if_id_valid = r_f1_valid;
  assign o_if_id_pc    = r_f1_pc;
  assign o_if_id_pc4   = r_f1_pc + 32'd4;

  always_comb begin
    o_if_id_instr = NOP_INSTR;
    if (r_f1_valid) begin
      o_if_id_instr = (r_state == S_HELD) ? r_hold_instr : i_imem_rdata;
    end
  end

  // Decode may only stall together with fetch.
  a_stall_order: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(i_stall_id && !i_stall_if));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, random run against a
// bundle-level reference model, and an async-reset-mid-stall sequence.
module tb_fetch_unit;
  import core_pkg::*;

  localparam logic [31:0] HI_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, stall_id, flush, rv;
  logic [31:0] rpc;
  logic        req, req_hi;
  logic [13:0] addr, addr_hi;
  logic [31:0] rdata, rdata_hi;
  logic        v, v_hi;
  logic [31:0] pc, pc_hi, pc4, pc4_hi, instr, instr_hi;

  int n_checks = 0;
  int n_errors = 0;

  logic        ovr_en;
  logic [13:0] ovr_addr;
  logic [31:0] ovr_val;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(14)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_stall_if(stall_if), .i_stall_id(stall_id),
    .i_flush_if_id(flush), .i_redirect_valid(rv), .i_redirect_pc(rpc),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_rdata(rdata),
    .o_if_id_valid(v), .o_if_id_pc(pc), .o_if_id_pc4(pc4), .o_if_id_instr(instr)
  );

  fetch_unit #(.RESET_PC(HI_PC), .IMEM_AW(14)) u_dut_hi (
    .i_clk(clk), .i_reset(rst_n), .i_stall_if(stall_if), .i_stall_id(stall_id),
    .i_flush_if_id(flush), .i_redirect_valid(rv), .i_redirect_pc(rpc),
    .o_imem_req(req_hi), .o_imem_addr(addr_hi), .i_imem_rdata(rdata_hi),
    .o_if_id_valid(v_hi), .o_if_id_pc(pc_hi), .o_if_id_pc4(pc4_hi),
    .o_if_id_instr(instr_hi)
  );

  // Synchronous memory: mem[a] = byte address a; garbage when not requested.
  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {16'h0000, a, 2'b00};
  endfunction

  always @(posedge clk) begin
    if (req) rdata <= (ovr_en && addr == ovr_addr) ? ovr_val : mem_word(addr);
    else     rdata <= $urandom;
    if (req_hi) rdata_hi <= mem_word(addr_hi);
    else        rdata_hi <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sif, input logic sid, input logic fl, input logic r,
                       input logic [31:0] t);
    stall_if = sif; stall_id = sid; flush = fl; rv = r; rpc = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sif, sid, fl, rv;
    logic [31:0] rpc;
    logic [13:0] addr;
    logic        req, valid;
    logic [31:0] pc, instr;
  } vec_t;

  function automatic vec_t mk(input logic sif, input logic sid, input logic fl,
                              input logic r, input logic [31:0] t, input logic [13:0] a,
                              input logic q, input logic vv, input logic [31:0] p,
                              input logic [31:0] i);
    vec_t x;
    x.sif = sif; x.sid = sid; x.fl = fl; x.rv = r; x.rpc = t;
    x.addr = a; x.req = q; x.valid = vv; x.pc = p; x.instr = i;
    return x;
  endfunction

  vec_t tbl[21];

  // Reference model state: next fetch PC and the bundle decode should be seeing.
  logic [31:0] m_pc, m_id_pc, m_id_instr;
  logic        m_valid;

  initial begin
    ovr_en = 1'b1; ovr_addr = 14'd2; ovr_val = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    //            sif  sid  fl   rv   rpc           addr    req  val  pc            instr
    tbl[0]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h000,1'b1,1'b0,32'h0,     NOP_INSTR);
    tbl[1]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h001,1'b1,1'b1,32'h0,     32'h0);
    tbl[2]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h002,1'b1,1'b1,32'h4,     32'h4);
    tbl[3]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,     14'h003,1'b0,1'b1,32'h8,     32'hDEAD_BEEF);
    tbl[4]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,     14'h003,1'b0,1'b1,32'h8,     32'hDEAD_BEEF);
    tbl[5]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,     14'h003,1'b0,1'b1,32'h8,     32'hDEAD_BEEF);
    tbl[6]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h003,1'b1,1'b1,32'h8,     32'hDEAD_BEEF);
    tbl[7]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h004,1'b1,1'b1,32'hC,     32'hC);
    tbl[8]  = mk(1'b0,1'b0,1'b0,1'b1,32'h100,   14'h005,1'b1,1'b1,32'h10,    32'h10);
    tbl[9]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h040,1'b1,1'b0,32'h0,     NOP_INSTR);
    tbl[10] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h041,1'b1,1'b1,32'h100,   32'h100);
    tbl[11] = mk(1'b1,1'b1,1'b0,1'b1,32'h202,   14'h042,1'b0,1'b1,32'h104,   32'h104);
    tbl[12] = mk(1'b0,1'b0,1'b0,1'b1,32'h202,   14'h042,1'b1,1'b1,32'h104,   32'h104);
    tbl[13] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h080,1'b1,1'b0,32'h0,     NOP_INSTR);
    tbl[14] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h081,1'b1,1'b1,32'h200,   32'h200);
    tbl[15] = mk(1'b0,1'b0,1'b1,1'b0,32'h0,     14'h082,1'b1,1'b1,32'h204,   32'h204);
    tbl[16] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h083,1'b1,1'b0,32'h0,     NOP_INSTR);
    tbl[17] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h084,1'b1,1'b1,32'h20C,   32'h20C);
    tbl[18] = mk(1'b1,1'b0,1'b0,1'b0,32'h0,     14'h085,1'b0,1'b1,32'h210,   32'h210);
    tbl[19] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h085,1'b1,1'b0,32'h0,     NOP_INSTR);
    tbl[20] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,     14'h086,1'b1,1'b1,32'h214,   32'h214);

    // Reset state.
    step(); step();
    check("rst.valid", 32'(v), 32'h0);
    check("rst.pc", pc, 32'h0);
    check("rst.pc4", pc4, 32'h4);
    check("rst.instr", instr, NOP_INSTR);
    check("rst.req", 32'(req), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].sif, tbl[i].sid, tbl[i].fl, tbl[i].rv, tbl[i].rpc);
      #1;
      check($sformatf("t%0d.req", i), 32'(req), 32'(tbl[i].req));
      check($sformatf("t%0d.addr", i), 32'(addr), 32'(tbl[i].addr));
      check($sformatf("t%0d.valid", i), 32'(v), 32'(tbl[i].valid));
      check($sformatf("t%0d.instr", i), instr, tbl[i].instr);
      if (tbl[i].valid) begin
        check($sformatf("t%0d.pc", i), pc, tbl[i].pc);
        check($sformatf("t%0d.pc4", i), pc4, tbl[i].pc + 32'd4);
      end
      step();
    end
    ovr_en = 1'b0;

    // Random run against the bundle-level model.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_pc = 32'h0; m_valid = 1'b0; m_id_pc = 32'h0; m_id_instr = NOP_INSTR;
    for (int n = 0; n < 400; n++) begin
      logic sif, sid, fl, r;
      logic [31:0] t;
      sif = ($urandom % 4) == 0;
      sid = sif && ($urandom % 2 == 0);
      fl  = ($urandom % 8) == 0;
      r   = ($urandom % 6) == 0;
      t   = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive(sif, sid, fl, r, t);
      #1;
      check("rnd.req", 32'(req), 32'(!sif));
      check("rnd.addr", 32'(addr), 32'(m_pc[15:2]));
      check("rnd.valid", 32'(v), 32'(m_valid));
      check("rnd.instr", instr, m_valid ? m_id_instr : NOP_INSTR);
      if (m_valid) begin
        check("rnd.pc", pc, m_id_pc);
        check("rnd.pc4", pc4, m_id_pc + 32'd4);
      end
      @(posedge clk);
      if (r && !sid) begin
        m_pc = t & 32'hFFFF_FFFC;
        m_valid = 1'b0;
      end else if (sid) begin
        // bundle and PC frozen
      end else if (sif) begin
        m_valid = 1'b0;
      end else if (fl) begin
        m_id_pc = m_pc; m_valid = 1'b0; m_pc = m_pc + 32'd4;
      end else begin
        m_id_pc = m_pc; m_id_instr = m_pc & 32'h0000_FFFC; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
      #1;
    end

    // Async reset mid-stall on the instance with RESET_PC = 0x8000_0000.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("hi.first_addr", 32'(addr_hi), 32'h0);
    check("hi.first_valid", 32'(v_hi), 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h38);
    #1;
    check("hi.boot_pc", pc_hi, HI_PC);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check("hi.stall_addr", 32'(addr_hi), 32'h10);
    check("hi.stall_pc", pc_hi, 32'h3C);
    step();
    #1;
    check("hi.held_instr", instr_hi, 32'h3C);
    rst_n = 1'b0;
    #1;
    check("hi.rst_valid", 32'(v_hi), 32'h0);
    check("hi.rst_instr", instr_hi, NOP_INSTR);
    check("hi.rst_pc4", pc4_hi, 32'h4);
    check("hi.rst_req", 32'(req_hi), 32'h0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("hi.restart_addr", 32'(addr_hi), 32'(HI_PC[15:2]));
    check("hi.restart_req", 32'(req_hi), 32'h1);
    check("hi.restart_valid", 32'(v_hi), 32'h0);
    step();
    check("hi.restart_pc", pc_hi, HI_PC);
    check("hi.restart_pc4", pc4_hi, HI_PC + 32'd4);
    check("hi.restart_instr", instr_hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage: PC register, synchronous I-memory request, and IF/ID pipeline register.
- Obeys the stall/flush controls produced by the hazard logic.
- Accepts taken-branch/jump redirects resolved in ID.
- Delivers a valid {pc, pc+4, instr} bundle to decode every cycle it is not stalled, and keeps that bundle stable while stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 14, I-memory word-address width; o_imem_addr = pc[IMEM_AW+1:2].

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_stall_if  in  1  hold PC.
- i_stall_id  in  1  hold IF/ID.
- i_flush_if_id  in  1  kill the IF/ID entry.
- i_redirect_valid  in  1  taken branch/jump resolved in ID.
- i_redirect_pc  in  32  redirect target.
- o_imem_req  out  1  read enable.
- o_imem_addr  out  IMEM_AW  word address.
- i_imem_rdata  in  32  read data; valid exactly 1 cycle after a request.
- o_if_id_valid  out  1  decode bundle valid.
- o_if_id_pc  out  32  PC of bundle.
- o_if_id_pc4  out  32  o_if_id_pc + 4.
- o_if_id_instr  out  32  instruction; NOP 32'h0000_0013 whenever o_if_id_valid=0.

Behaviour:
- State:
  - pc_q (next fetch PC).
  - f1_valid, f1_pc (IF/ID metadata).
  - hold_valid, hold_instr (stall capture buffer).
  - FSM {S_RUN, S_HELD} encoded by hold_valid.
- Reset (async, asserted low):
  - pc_q=RESET_PC; f1_valid=0; f1_pc=0; hold_valid=0; hold_instr=NOP.
  - Outputs during and after reset: o_if_id_valid=0, o_if_id_pc=0, o_if_id_pc4=4, o_if_id_instr=NOP, o_imem_req=0.
  - o_imem_req=1 from the first cycle after deassertion.
- Combinational outputs:
  - o_imem_addr = pc_q[IMEM_AW+1:2].
  - o_imem_req = !i_stall_if.
  - o_if_id_instr = !f1_valid ? NOP : (hold_valid ? hold_instr : i_imem_rdata).
- Per-edge priority, highest first:
  1. Redirect: i_redirect_valid && !i_stall_id.
     - pc_q <= {i_redirect_pc[31:2],2'b00}; f1_valid <= 0; hold_valid <= 0.
     - Wrong-path fetch is dropped; exactly 1 bubble reaches ID.
     - Redirect with i_stall_id=1 is ignored; the branch is still held in ID and re-asserts.
  2. Full stall: i_stall_if && i_stall_id.
     - pc_q, f1_valid, f1_pc hold.
     - If hold_valid=0: hold_instr <= i_imem_rdata, hold_valid <= 1 (S_RUN->S_HELD).
     - If hold_valid=1: no change.
     - The instruction is captured on the first stall edge because the memory output is not guaranteed stable without a request.
  3. Flush: i_flush_if_id, no stall.
     - f1_valid <= 0; hold_valid <= 0.
     - pc_q advances normally: pc_q <= pc_q+4, f1_pc <= pc_q.
     - The fetch issued this cycle is discarded. Flush dominates its own fetch only; the next fetch is valid.
  4. PC-only stall: i_stall_if && !i_stall_id.
     - pc_q holds; f1_valid <= 0 (bubble into ID); hold_valid <= 0.
  5. Run:
     - pc_q <= pc_q+4; f1_pc <= pc_q; f1_valid <= 1; hold_valid <= 0 (S_HELD->S_RUN).
- i_stall_id && !i_stall_if is illegal.
  - Assertion fires.
  - RTL treats it as a full stall.
- Latency: address issued in cycle N → bundle visible at decode in cycle N+1.
- Arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Redirect into the same cycle as a stall release is legal. Redirect priority applies; the held instruction is discarded.
- Reset mid-stall: buffer cleared; fetch restarts at RESET_PC.

Decomposition:
- Shared package (core_pkg): XLEN=32, NOP_INSTR=32'h0000_0013, fetch_state_e {S_RUN, S_HELD}.
- No sub-module required; the hold buffer is ~20 lines inline.
- Optional: fetch_hold_buf if reused for the data-memory load path.

Test Plan:
1. Reset, then run, 6 cycles; memory returns mem[a]=a.
   - ID sees pc 0,4,8,12,16 on consecutive cycles, valid=1 from cycle 2.
   - instr at reset = NOP, valid=0.
2. Stall at pc 8 for 3 cycles; memory returns 32'hDEAD_BEEF in stall cycle 1, then garbage.
   - o_if_id_pc=8 and o_if_id_instr=DEADBEEF held all 3 cycles.
   - o_imem_req=0 while stalled.
   - pc 12 appears 1 cycle after release.
3. Redirect to 32'h0000_0100 while ID holds pc 16.
   - Next cycle valid=0 with instr=NOP.
   - Following cycle pc=0x100.
   - Fetch of 20 is never seen valid.
4. i_redirect_valid=1 together with full stall; release next cycle with the redirect held.
   - Redirect taken only on the release edge; stalled bundle is unchanged during the stall.
5. i_flush_if_id pulse with no stall at pc 24.
   - 1 bubble (valid=0, NOP); stream resumes at pc 28 with no PC skip.
6. Async reset asserted mid-stall with pc_q=0x40.
   - Immediate valid=0; after deassertion fetch restarts at RESET_PC; with RESET_PC=0x8000_0000, first pc = 0x8000_0000.
